// File: rtl/piezo_sfx_if.sv
// piezo_sfx_if: sound-command and piezo/status signals between the game core (master) and the player (slave).
interface piezo_sfx_if;
  logic [1:0] i_Sound_Cmd;
  logic       o_Piezo;
  logic       o_Busy;
  logic [1:0] o_Effect;
  modport master(output i_Sound_Cmd, input o_Piezo, o_Busy, o_Effect);
  modport slave(input i_Sound_Cmd, output o_Piezo, o_Busy, o_Effect);
endinterface

// File: rtl/piezo_sfx_player.sv
// piezo_sfx_player: edge-triggered square-wave sound-effect sequencer driving the piezo pin.
// Define SFX_PREEMPT_EN to let equal/higher-code requests restart playback while busy.
module piezo_sfx_player #(
  parameter int CLK_HZ = 50_000_000,
  parameter int GAP_MS = 2
) (
  input logic        i_Clk,
  input logic        i_Rst,
  piezo_sfx_if.slave sfx
);
  localparam int TICK = CLK_HZ / 1000;
  localparam int PW = (TICK > 1) ? $clog2(TICK) : 1;
  function automatic logic [19:0] hp_of(input int f);
    int h;
    h = CLK_HZ / (2 * f);
    return (h < 1) ? 20'd1 : h[19:0];
  endfunction
  // Flattened note ROM: hit at 0, miss at 1..2, game-over at 3..5
  localparam logic [19:0] HP [6] = '{hp_of(1047), hp_of(220), hp_of(196),
                                     hp_of(523), hp_of(392), hp_of(262)};
  localparam logic [15:0] DUR [6] = '{16'd60, 16'd80, 16'd120, 16'd150, 16'd150, 16'd300};
  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;
  state_t      state_q;
  logic [1:0]  prev_q, effect_q, idx_q;
  logic [19:0] hp_cnt_q;
  logic [PW-1:0] pre_q;
  logic [15:0] ms_q;
  logic        piezo_q, busy_q;
  logic [2:0]  sel;
  logic [19:0] hp;
  logic [15:0] dur;
  logic        tick, hp_wrap, last, note_end, gap_end, req, start;
  always_comb begin
    sel = (effect_q == 2'd1) ? 3'd0 :
          (effect_q == 2'd2) ? 3'd1 + {1'b0, idx_q} : 3'd3 + {1'b0, idx_q};
    hp = HP[sel];
    dur = DUR[sel];
    tick = pre_q == PW'(TICK - 1);
    hp_wrap = hp_cnt_q == hp - 20'd1;
    last = idx_q == effect_q - 2'd1;
    note_end = (state_q == PLAY) && tick && (ms_q == dur - 16'd1);
    gap_end = (state_q == GAP) && tick && (ms_q == 16'(GAP_MS - 1));
    req = (sfx.i_Sound_Cmd != 2'd0) && (sfx.i_Sound_Cmd != prev_q);
`ifdef SFX_PREEMPT_EN
    start = req && ((state_q == IDLE) || (note_end && last) || (sfx.i_Sound_Cmd >= effect_q));
`else
    start = req && ((state_q == IDLE) || (note_end && last));
`endif
  end
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q  <= IDLE;
      prev_q   <= 2'd0;
      effect_q <= 2'd0;
      idx_q    <= 2'd0;
      hp_cnt_q <= '0;
      pre_q    <= '0;
      ms_q     <= '0;
      piezo_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      prev_q <= sfx.i_Sound_Cmd;
      if (state_q != IDLE) begin
        pre_q    <= tick ? '0 : pre_q + PW'(1);
        ms_q     <= tick ? ms_q + 16'd1 : ms_q;
        hp_cnt_q <= hp_wrap ? 20'd0 : hp_cnt_q + 20'd1;
      end
      if (start) begin
        state_q  <= PLAY;
        effect_q <= sfx.i_Sound_Cmd;
        idx_q    <= 2'd0;
        busy_q   <= 1'b1;
        piezo_q  <= 1'b0;
        hp_cnt_q <= '0;
        pre_q    <= '0;
        ms_q     <= '0;
      end else if (note_end) begin
        state_q  <= last ? IDLE : GAP;
        effect_q <= last ? 2'd0 : effect_q;
        busy_q   <= !last;
        piezo_q  <= 1'b0;
        hp_cnt_q <= '0;
        pre_q    <= '0;
        ms_q     <= '0;
      end else if (gap_end) begin
        state_q  <= PLAY;
        idx_q    <= idx_q + 2'd1;
        hp_cnt_q <= '0;
        pre_q    <= '0;
        ms_q     <= '0;
      end else if (state_q == PLAY && hp_wrap) begin
        piezo_q <= !piezo_q;
      end
    end
  end
  assign sfx.o_Piezo  = piezo_q;
  assign sfx.o_Busy   = busy_q;
  assign sfx.o_Effect = effect_q;
endmodule
